// File: rtl/fetch_unit_pkg.sv
// Shared fetch/decode types: the {pc, instr} entry handed to decode and the
// occupancy states of the fetch output buffer.
package fetch_unit_pkg;

   localparam int INSTR_W = 32;
   localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0]        pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_state_e;

   // A PC can be fetched only if it is word-aligned and inside the ROM.
   function automatic logic pc_fetchable(input logic [31:0] pc, input logic [31:0] limit);
      return (pc[1:0] == 2'b00) && (pc < limit);
   endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry valid/ready buffer of fetch entries; flush empties it in one cycle
// and takes priority over push and pop.
module fetch_skid_buf
   import fetch_unit_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  fetch_entry_t push_entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic         valid_o,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   buf_state_e   state_q, state_d;
   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         // NOTE: the entry registers are reset too, because the head is
         // visible on out_pc/out_instr and must read zero after reset.
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a hold value first so no path can infer a latch.
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush_i) begin
         state_d = BUF_EMPTY;
      end else begin
         case (state_q)
            BUF_EMPTY: begin
               if (push_i) begin
                  head_d  = push_entry_i;
                  state_d = BUF_ONE;
               end
            end
            BUF_ONE: begin
               case ({push_i, pop_i})
                  2'b11: head_d = push_entry_i;
                  2'b10: begin
                     tail_d  = push_entry_i;
                     state_d = BUF_FULL;
                  end
                  2'b01: state_d = BUF_EMPTY;
                  default: ;
               endcase
            end
            BUF_FULL: begin
               // Push into a full buffer only happens alongside a pop.
               if (pop_i) begin
                  head_d = tail_q;
                  if (push_i) tail_d = push_entry_i;
                  else        state_d = BUF_ONE;
               end
            end
            default: state_d = BUF_EMPTY;
         endcase
      end
   end

   assign valid_o = (state_q != BUF_EMPTY);
   assign head_o  = head_q;
   assign count_o = state_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM and queues
// {pc, instr} pairs for decode; redirects flush the queue and reload the PC.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_000C,
   parameter int          ROM_WORDS = 64,
   parameter int          DEPTH     = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [31:0]        redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic               fault
);

   localparam logic [31:0] PC_LIMIT = 32'(ROM_WORDS * 4);

   logic [31:0]  pc_q, pc_d;
   logic         fault_q, fault_d;
   logic         in_range;
   logic         has_room;
   logic         push;
   logic         pop;
   logic [1:0]   buf_count;
   fetch_entry_t push_entry;
   fetch_entry_t head;

   assign in_range = (pc_q < PC_LIMIT);
   assign has_room = (int'(buf_count) < DEPTH);
   assign pop      = out_valid & out_ready & ~redirect_valid;
   assign push     = ~fault_q & ~redirect_valid & in_range & (has_room | pop);

   assign push_entry = '{pc: pc_q, instr: imem_rdata};

   always_comb begin
      pc_d    = pc_q;
      fault_d = fault_q;
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         fault_d = ~pc_fetchable(redirect_pc, PC_LIMIT);
      end else if (push) begin
         pc_d = pc_q + 32'd4;
      end else if (!fault_q && !in_range) begin
         // Sequential fetch ran off the end of the ROM; halt until redirected.
         fault_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         fault_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         fault_q <= fault_d;
      end
   end

   fetch_skid_buf u_skid_buf (
      .clk          (clk),
      .rst_n        (rst_n),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .flush_i      (redirect_valid),
      .valid_o      (out_valid),
      .head_o       (head),
      .count_o      (buf_count)
   );

   assign imem_addr = pc_q;
   assign out_pc    = head.pc;
   assign out_instr = head.instr;
   assign fault     = fault_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage sitting directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM word address.
- Captures the combinational ROM read data and hands {pc, instr} pairs to decode over a valid/ready interface.
- A 2-entry buffer decouples decode stalls from fetch; branch/jump redirects from execute flush the buffer and reload the PC.

Parameters:
- RESET_PC, 32'h0000_000C, boot vector loaded into the PC at reset.
- ROM_WORDS, 64, number of 32-bit words in the instruction ROM; fetch addresses at or above ROM_WORDS*4 are out of range.
- DEPTH, 2, output buffer entries; fixed at 2 (skid buffer). Other values are not supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- imem_addr  out  32  byte address to the ROM; equals the current PC, combinational from the PC register.
- imem_rdata  in  32  ROM read word; combinational, valid in the same cycle as imem_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  32  target byte address for the redirect.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_pc  out  32  PC of the head entry.
- out_instr  out  32  instruction word of the head entry.
- fault  out  1  sticky fetch fault (misaligned or out-of-range PC); fetch is halted while high.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - pc = RESET_PC; buffer count = 0.
  - out_valid = 0, out_pc = 0, out_instr = 0, fault = 0.
  - Reset mid-operation discards all buffered entries; there is no partial state.
- imem_addr = pc at all times, including during reset.
- pop = out_valid & out_ready & ~redirect_valid.
- push = ~fault & ~redirect_valid & in_range(pc) & (count < 2 | pop).
  - On push: enqueue {pc, imem_rdata}, then pc <= pc + 4 (32-bit wrap; unreachable in practice because the range check fires first).
- Latency:
  - The first instruction is presented with out_valid=1 in the cycle after rst_n deasserts.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Buffer state and transitions:
  - States: EMPTY (count 0), ONE (count 1), FULL (count 2).
  - Push only: count +1. Pop only: count -1. Push and pop together: count unchanged; FIFO order is preserved.
  - In FULL with out_ready=0: no push; the PC holds.
- Head stability: while out_valid=1 and out_ready=0, out_pc and out_instr must not change (valid/ready rule). out_valid never drops without a pop, except on redirect or reset.
- Redirect (redirect_valid=1):
  - Has highest priority over push and pop.
  - Buffer is flushed (count <= 0, out_valid = 0 next cycle).
  - pc <= redirect_pc.
  - No push and no pop occur in that cycle, even if out_ready=1.
  - If redirect_pc[1:0] != 0 or redirect_pc >= ROM_WORDS*4: fault <= 1. Otherwise fault <= 0.
  - Redirect is the only way to clear fault.
- Out-of-range sequential fetch: when pc >= ROM_WORDS*4 and no redirect, fault <= 1 and no push occurs. Entries already buffered still drain normally.
- Redirect to the current pc is legal: flush and refetch.
- Invariant: out_valid == (count != 0).

Decomposition:
- Shared package holds:
  - constant INSTR_W = 32;
  - constant NOP = 32'h0000_0013;
  - a packed typedef fetch_entry_t {pc[31:0], instr[31:0]}, reused by decode.
- One sub-module: fetch_skid_buf, a 2-entry valid/ready buffer of fetch_entry_t with push/pop/flush inputs.
- The PC register, range check, and fault logic stay in fetch_unit.

Test Plan:
- Reset release, ROM words 0x55500093, 0x00102023 at 0xC and 0x10, out_ready=1 -> cycles 1, 2 show out_pc 0xC, 0x10 with those instructions, out_valid=1 continuously.
- out_ready=0 for 5 cycles after reset -> count reaches 2; imem_addr holds 0x14; head stays 0xC/0x55500093. Raising out_ready then delivers 0xC, 0x10, 0x14 back-to-back with no gap.
- redirect_valid=1 with redirect_pc=0x24 while FULL and out_ready=1 -> no handshake that cycle; out_valid=0 next cycle; then out_pc=0x24.
- redirect_pc=0x26 -> fault=1 next cycle, out_valid stays 0. A later redirect to 0x0C clears fault and resumes fetch at 0x0C.
- Free-run to pc=0xFC with ROM_WORDS=64 -> 0xFC is delivered; pc becomes 0x100; fault=1; no further pushes.
- rst_n=0 asserted while FULL -> next cycle out_valid=0, fault=0, imem_addr=0xC.
